// File: rtl/mem_rdata_return.sv
// Read-data return path of the banked SRAM controller: delays each accepted read's
// bank/macro tag to match macro latency, then registers the selected byte to the host.
module mem_rdata_return #(
    parameter int READ_LAT = 1,
    parameter int DW       = 8,
    parameter int NMAC     = 16
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic [15:0]          ADDR,
    input  logic                 CE,
    input  logic                 CSB,
    input  logic                 WEB,
    input  logic                 OEB,
    input  logic [NMAC*DW-1:0]   MEM_ODATA_BANK1,
    input  logic [NMAC*DW-1:0]   MEM_ODATA_BANK2,
    input  logic [NMAC*DW-1:0]   MEM_ODATA_BANK3,
    input  logic [NMAC*DW-1:0]   MEM_ODATA_BANK4,
    output logic [DW-1:0]        ODATA,
    output logic                 ODATA_VALID,
    output logic                 BUSY,
    output logic [15:0]          RD_CNT
);

    logic                rd_req;
    logic [READ_LAT:0]   tag_vld;
    logic [1:0]          tag_bank [READ_LAT+1];
    logic [3:0]          tag_mac  [READ_LAT+1];
    logic [NMAC*DW-1:0]  bank_data;
    logic [DW-1:0]       sel_byte;
    logic                unused_addr;

    assign rd_req      = CE & ~CSB & WEB & ~OEB;
    assign unused_addr = ^ADDR[9:0];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tag_vld <= '0;
            for (int k = 0; k <= READ_LAT; k++) begin
                tag_bank[k] <= '0;
                tag_mac[k]  <= '0;
            end
        end else begin
            tag_vld     <= {tag_vld[READ_LAT-1:0], rd_req};
            tag_bank[0] <= ADDR[15:14];
            tag_mac[0]  <= ADDR[13:10];
            for (int k = 1; k <= READ_LAT; k++) begin
                tag_bank[k] <= tag_bank[k-1];
                tag_mac[k]  <= tag_mac[k-1];
            end
        end
    end

    // The macros were addressed on the edge that loaded stage 0, so their data is
    // stable once the tag has advanced READ_LAT edges, i.e. into the last stage.
    always_comb begin
        bank_data = MEM_ODATA_BANK1;
        case (tag_bank[READ_LAT])
            2'd0:    bank_data = MEM_ODATA_BANK1;
            2'd1:    bank_data = MEM_ODATA_BANK2;
            2'd2:    bank_data = MEM_ODATA_BANK3;
            default: bank_data = MEM_ODATA_BANK4;
        endcase
    end

    assign sel_byte = bank_data[DW*int'(tag_mac[READ_LAT]) +: DW];

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ODATA       <= '0;
            ODATA_VALID <= 1'b0;
            RD_CNT      <= '0;
        end else begin
            ODATA_VALID <= tag_vld[READ_LAT];
            if (tag_vld[READ_LAT]) begin
                ODATA  <= sel_byte;
                RD_CNT <= RD_CNT + 16'd1;
            end
        end
    end

    assign BUSY = |tag_vld[READ_LAT-1:0];

endmodule

// File: tb/tb_mem_rdata_return.sv
// Directed bench for mem_rdata_return: READ_LAT=1 instance for most checks plus a
// READ_LAT=3 instance sharing the same stimulus for the latency cases.
module tb_mem_rdata_return;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic [15:0]  ADDR;
    logic         CE, CSB, WEB, OEB;
    logic [127:0] mem1, mem2, mem3, mem4;
    logic [7:0]   odata, odata3;
    logic         ovld, ovld3, busy, busy3;
    logic [15:0]  rd_cnt, rd_cnt3;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    mem_rdata_return #(.READ_LAT(1), .DW(8), .NMAC(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .MEM_ODATA_BANK1(mem1), .MEM_ODATA_BANK2(mem2),
        .MEM_ODATA_BANK3(mem3), .MEM_ODATA_BANK4(mem4),
        .ODATA(odata), .ODATA_VALID(ovld), .BUSY(busy), .RD_CNT(rd_cnt)
    );

    mem_rdata_return #(.READ_LAT(3), .DW(8), .NMAC(16)) dut3 (
        .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .MEM_ODATA_BANK1(mem1), .MEM_ODATA_BANK2(mem2),
        .MEM_ODATA_BANK3(mem3), .MEM_ODATA_BANK4(mem4),
        .ODATA(odata3), .ODATA_VALID(ovld3), .BUSY(busy3), .RD_CNT(rd_cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic ce, input logic csb, input logic web, input logic oeb,
                       input logic [15:0] a);
        CE = ce; CSB = csb; WEB = web; OEB = oeb; ADDR = a;
    endtask

    task automatic drv_idle();
        drv(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000);
    endtask

    task automatic drv_rd(input logic [15:0] a);
        drv(1'b1, 1'b0, 1'b1, 1'b0, a);
    endtask

    logic [15:0] burst_addr [4];
    logic [7:0]  burst_data [4];
    int          pulses, pulses3;
    logic [7:0]  exp_od;

    initial begin
        burst_addr[0] = 16'h3C00; burst_addr[1] = 16'h7C00;
        burst_addr[2] = 16'hBC00; burst_addr[3] = 16'hFFFF;
        burst_data[0] = 8'h11; burst_data[1] = 8'h22;
        burst_data[2] = 8'h33; burst_data[3] = 8'h44;
        mem1 = 'x; mem2 = 'x; mem3 = 'x; mem4 = 'x;
        RSTN = 1'b0;
        drv_idle();
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;

        // Reset then idle
        repeat (10) @(negedge CLK);
        chk("rst_odata", {24'd0, odata}, 32'h00);
        chk("rst_valid", {31'd0, ovld}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdcnt", {16'd0, rd_cnt}, 32'd0);

        // Single read bank 2 macro 3, both latencies
        mem2[31:24] = 8'hA5;
        drv_rd(16'h4C00);
        for (int k = 0; k <= 5; k++) begin
            @(negedge CLK);
            drv_idle();
            chk($sformatf("single_valid_k%0d", k), {31'd0, ovld}, {31'd0, k == 2});
            chk($sformatf("single3_valid_k%0d", k), {31'd0, ovld3}, {31'd0, k == 4});
            chk($sformatf("single_busy_k%0d", k), {31'd0, busy}, {31'd0, k == 0});
            chk($sformatf("single3_busy_k%0d", k), {31'd0, busy3}, {31'd0, k <= 2});
            if (k == 2) chk("single_odata", {24'd0, odata}, 32'hA5);
            if (k == 4) chk("single3_odata", {24'd0, odata3}, 32'hA5);
        end
        chk("single_rdcnt", {16'd0, rd_cnt}, 32'd1);
        chk("single3_rdcnt", {16'd0, rd_cnt3}, 32'd1);

        // Back-to-back burst, banks 1..4 macro 15
        mem1[127:120] = 8'h11; mem2[127:120] = 8'h22;
        mem3[127:120] = 8'h33; mem4[127:120] = 8'h44;
        for (int k = 0; k <= 6; k++) begin
            if (k < 4) drv_rd(burst_addr[k]); else drv_idle();
            @(negedge CLK);
            chk($sformatf("burst_valid_k%0d", k), {31'd0, ovld}, {31'd0, k >= 2 && k <= 5});
            chk($sformatf("burst_busy_k%0d", k), {31'd0, busy}, {31'd0, k <= 3});
            if (k >= 2 && k <= 5)
                chk($sformatf("burst_odata_k%0d", k), {24'd0, odata}, {24'd0, burst_data[k-2]});
        end
        drv_idle();
        chk("burst_rdcnt", {16'd0, rd_cnt}, 32'd5);

        // Read, write, CSB=1, OEB=1, read
        mem1[47:40] = 8'h5A;
        mem3[71:64] = 8'hC3;
        pulses = 0;
        for (int k = 0; k <= 8; k++) begin
            case (k)
                0:       drv_rd(16'h1400);
                1:       drv(1'b1, 1'b0, 1'b0, 1'b0, 16'h4C00);
                2:       drv(1'b1, 1'b1, 1'b1, 1'b0, 16'h4C00);
                3:       drv(1'b1, 1'b0, 1'b1, 1'b1, 16'h4C00);
                4:       drv_rd(16'hA155);
                default: drv_idle();
            endcase
            @(negedge CLK);
            if (ovld === 1'b1) pulses++;
            exp_od = (k < 2) ? 8'h44 : (k < 6) ? 8'h5A : 8'hC3;
            chk($sformatf("mixed_valid_k%0d", k), {31'd0, ovld}, {31'd0, k == 2 || k == 6});
            chk($sformatf("mixed_odata_k%0d", k), {24'd0, odata}, {24'd0, exp_od});
        end
        drv_idle();
        chk("mixed_pulses", pulses, 32'd2);
        chk("mixed_rdcnt", {16'd0, rd_cnt}, 32'd7);

        // Reset one cycle after a read request
        drv_rd(16'h4C00);
        @(negedge CLK);
        drv_idle();
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        chk("midrst_odata", {24'd0, odata}, 32'h00);
        chk("midrst_valid", {31'd0, ovld}, 32'd0);
        chk("midrst_busy3", {31'd0, busy3}, 32'd0);
        chk("midrst_rdcnt", {16'd0, rd_cnt}, 32'd0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        pulses = 0; pulses3 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (ovld === 1'b1) pulses++;
            if (ovld3 === 1'b1) pulses3++;
        end
        chk("midrst_pulses", pulses, 32'd0);
        chk("midrst_pulses3", pulses3, 32'd0);
        chk("midrst_odata_after", {24'd0, odata}, 32'h00);
        chk("midrst_rdcnt_after", {16'd0, rd_cnt}, 32'd0);
        chk("midrst_rdcnt3_after", {16'd0, rd_cnt3}, 32'd0);
        chk("midrst_busy_after", {31'd0, busy}, 32'd0);

        // RD_CNT wrap
        drv_rd(16'h4C00);
        repeat (65535) @(negedge CLK);
        drv_idle();
        repeat (6) @(negedge CLK);
        chk("wrap_pre", {16'd0, rd_cnt}, 32'hFFFF);
        chk("wrap3_pre", {16'd0, rd_cnt3}, 32'hFFFF);
        drv_rd(16'h4C00);
        @(negedge CLK);
        drv_idle();
        repeat (6) @(negedge CLK);
        chk("wrap_post", {16'd0, rd_cnt}, 32'h0000);
        chk("wrap3_post", {16'd0, rd_cnt3}, 32'h0000);

        // READ_LAT=3 single read with fresh data
        mem2[31:24] = 8'h96;
        drv_rd(16'h4C00);
        for (int k = 0; k <= 5; k++) begin
            @(negedge CLK);
            drv_idle();
            chk($sformatf("lat3_valid_k%0d", k), {31'd0, ovld3}, {31'd0, k == 4});
            chk($sformatf("lat3_odata_k%0d", k), {24'd0, odata3}, (k < 4) ? 32'hA5 : 32'h96);
        end
        chk("lat3_rdcnt", {16'd0, rd_cnt3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
